cic_decim_iq: RTL and testbench

CIC_DECIM_IQ -- requirements
Module: cic_decim_iq

---
 rtl/cic_pkg.sv | 24 ++
 rtl/cic_chan.sv | 95 +++++++++
 rtl/cic_decim_iq.sv | 113 +++++++++++
 tb/tb_cic_decim_iq.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared constants and helpers for the I/Q CIC decimator: accumulator sizing,
// decimation-ratio limits and the output saturation test.
package cic_pkg;

   localparam int R_MIN = 2;

   function automatic int acc_width(input int in_w, input int stages, input int rate_log2);
      return in_w + stages * rate_log2;
   endfunction

   function automatic int rate_max(input int rate_log2);
      return 1 << rate_log2;
   endfunction

   // True when x lies outside the signed out_w-bit range; accumulators up to 64 bits.
   function automatic logic sat_hit(input logic signed [63:0] x, input int out_w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      return (x > hi) || (x < lo);
   endfunction

endpackage

// File: rtl/cic_chan.sv
// One CIC channel: pipelined integrator cascade, decimated comb pipeline and
// the shift/saturate stage feeding the shared output register.
module cic_chan
   import cic_pkg::*;
#(
   parameter int IN_W      = 8,
   parameter int OUT_W     = 16,
   parameter int STAGES    = 4,
   parameter int RATE_LOG2 = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_in_en,
   input  logic signed [IN_W-1:0]  i_x,
   input  logic                    i_snap,
   input  logic [STAGES-1:0]       i_comb_en,
   input  logic [5:0]              i_shift,
   output logic signed [OUT_W-1:0] o_y,
   output logic                    o_sat
);

   localparam int ACC_W = acc_width(IN_W, STAGES, RATE_LOG2);
   localparam logic signed [OUT_W-1:0] SMAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] SMIN = {1'b1, {(OUT_W-1){1'b0}}};

   function automatic logic signed [ACC_W-1:0] arith_shift(input logic signed [ACC_W-1:0] x,
                                                           input logic [5:0] sh);
      logic signed [ACC_W-1:0] r;
      if (32'(sh) >= ACC_W) r = {ACC_W{x[ACC_W-1]}};
      else                  r = x >>> sh;
      return r;
   endfunction

   logic signed [ACC_W-1:0] w_x_ext;
   logic signed [ACC_W-1:0] r_int     [STAGES];
   logic signed [ACC_W-1:0] r_snap_p0;
   logic signed [ACC_W-1:0] r_comb    [STAGES];
   logic signed [ACC_W-1:0] r_dly     [STAGES];
   logic signed [ACC_W-1:0] w_comb_in [STAGES];
   logic signed [ACC_W-1:0] w_sh;
   logic signed [63:0]      w_sh64;
   logic                    w_hit;

   assign w_x_ext = ACC_W'(i_x);

   // Integrators: one register per stage, each adding the previous stage's register.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) r_int[k] <= '0;
      end else if (i_in_en) begin
         r_int[0] <= r_int[0] + w_x_ext;
         for (int k = 1; k < STAGES; k++) r_int[k] <= r_int[k] + r_int[k-1];
      end
   end

   // Decimation point: snapshot of the last integrator at each period end.
   always_ff @(posedge clk) begin
      if (rst)         r_snap_p0 <= '0;
      else if (i_snap) r_snap_p0 <= r_int[STAGES-1];
   end

   always_comb begin
      w_comb_in[0] = r_snap_p0;
      for (int k = 1; k < STAGES; k++) w_comb_in[k] = r_comb[k-1];
   end

   // Combs: each stage fires once as the decimated sample ripples through.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            r_comb[k] <= '0;
            r_dly[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (i_comb_en[k]) begin
               r_comb[k] <= w_comb_in[k] - r_dly[k];
               r_dly[k]  <= w_comb_in[k];
            end
         end
      end
   end

   assign w_sh   = arith_shift(r_comb[STAGES-1], i_shift);
   assign w_sh64 = 64'(w_sh);
   assign w_hit  = sat_hit(w_sh64, OUT_W);

   always_comb begin
      o_y = w_sh64[OUT_W-1:0];
      if (w_hit) o_y = w_sh64[63] ? SMIN : SMAX;
   end

   assign o_sat = w_hit;

endmodule

// File: rtl/cic_decim_iq.sv
// I/Q CIC decimator top: sample counter, ratio latch, valid pipeline and the
// held output register with sticky overrun/saturation flags.
module cic_decim_iq
   import cic_pkg::*;
#(
   parameter int IN_W      = 8,
   parameter int OUT_W     = 16,
   parameter int STAGES    = 4,
   parameter int RATE_LOG2 = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic signed [IN_W-1:0]  in_i,
   input  logic signed [IN_W-1:0]  in_q,
   input  logic [RATE_LOG2:0]      rate,
   input  logic [5:0]              shift,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_i,
   output logic signed [OUT_W-1:0] out_q,
   output logic                    overrun,
   output logic                    sat
);

   localparam logic [RATE_LOG2:0] REFF_MIN = (RATE_LOG2+1)'(R_MIN);
   localparam logic [RATE_LOG2:0] REFF_MAX = (RATE_LOG2+1)'(rate_max(RATE_LOG2));

   logic [RATE_LOG2:0]      r_reff;
   logic [RATE_LOG2:0]      r_cnt;
   logic [RATE_LOG2:0]      w_reff_nxt;
   logic                    w_last;
   logic [STAGES:0]         r_vld_p;
   logic                    w_load;
   logic signed [OUT_W-1:0] w_y_i;
   logic signed [OUT_W-1:0] w_y_q;
   logic                    w_sat_i;
   logic                    w_sat_q;
   logic                    r_out_valid;
   logic signed [OUT_W-1:0] r_out_i;
   logic signed [OUT_W-1:0] r_out_q;
   logic                    r_overrun;
   logic                    r_sat;

   always_comb begin
      w_reff_nxt = rate;
      if (rate < REFF_MIN)      w_reff_nxt = REFF_MIN;
      else if (rate > REFF_MAX) w_reff_nxt = REFF_MAX;
   end

   assign w_last = in_valid && (r_cnt == r_reff - 1'b1);

   // Ratio is re-latched only while in reset and on the sample closing a period.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_reff <= w_reff_nxt;
      end else if (w_last) begin
         r_cnt  <= '0;
         r_reff <= w_reff_nxt;
      end else if (in_valid) begin
         r_cnt  <= r_cnt + 1'b1;
      end
   end

   // Bit 0 marks the snapshot, bit k marks comb stage k-1 done, top bit loads the output.
   always_ff @(posedge clk) begin
      if (rst) r_vld_p <= '0;
      else     r_vld_p <= {r_vld_p[STAGES-1:0], w_last};
   end

   assign w_load = r_vld_p[STAGES];

   cic_chan #(
      .IN_W(IN_W), .OUT_W(OUT_W), .STAGES(STAGES), .RATE_LOG2(RATE_LOG2)
   ) u_chan_i (
      .clk(clk), .rst(rst), .i_in_en(in_valid), .i_x(in_i), .i_snap(w_last),
      .i_comb_en(r_vld_p[STAGES-1:0]), .i_shift(shift), .o_y(w_y_i), .o_sat(w_sat_i)
   );

   cic_chan #(
      .IN_W(IN_W), .OUT_W(OUT_W), .STAGES(STAGES), .RATE_LOG2(RATE_LOG2)
   ) u_chan_q (
      .clk(clk), .rst(rst), .i_in_en(in_valid), .i_x(in_q), .i_snap(w_last),
      .i_comb_en(r_vld_p[STAGES-1:0]), .i_shift(shift), .o_y(w_y_q), .o_sat(w_sat_q)
   );

   // A new result always wins over a same-cycle handshake; overwrite only flags when unconsumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_i     <= '0;
         r_out_q     <= '0;
         r_overrun   <= 1'b0;
         r_sat       <= 1'b0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_i     <= w_y_i;
         r_out_q     <= w_y_q;
         if (r_out_valid && !out_ready) r_overrun <= 1'b1;
         if (w_sat_i || w_sat_q)        r_sat     <= 1'b1;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_i     = r_out_i;
   assign out_q     = r_out_q;
   assign overrun   = r_overrun;
   assign sat       = r_sat;

endmodule

// File: tb/tb_cic_decim_iq.sv
// Scoreboard bench for cic_decim_iq: the driver queues expected results per
// completed period, a negedge monitor checks data and latency on each arrival.
module tb_cic_decim_iq;

   localparam int IN_W = 8, OUT_W = 16, STAGES = 4, RATE_LOG2 = 12;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    in_valid = 1'b0;
   logic signed [IN_W-1:0]  in_i = '0;
   logic signed [IN_W-1:0]  in_q = '0;
   logic [RATE_LOG2:0]      rate = 13'd16;
   logic [5:0]              shift = 6'd16;
   logic                    out_ready = 1'b1;
   logic                    out_valid;
   logic signed [OUT_W-1:0] out_i;
   logic signed [OUT_W-1:0] out_q;
   logic                    overrun;
   logic                    sat;

   cic_decim_iq #(.IN_W(IN_W), .OUT_W(OUT_W), .STAGES(STAGES), .RATE_LOG2(RATE_LOG2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
      .rate(rate), .shift(shift), .out_valid(out_valid), .out_ready(out_ready),
      .out_i(out_i), .out_q(out_q), .overrun(overrun), .sat(sat)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int ei;
      int eq;
      bit chk;
      int ecyc;
   } exp_t;

   exp_t q_exp[$];
   int   n_chk = 0, n_fail = 0, n_arr = 0;
   int   b_cnt = 0, b_reff = 16, out_idx = 0, push_left = -1;
   bit   use_tab = 1'b0;
   int   ai = 0, aq = 0, st_i = 0, st_q = 0;
   // Transient outputs for a constant unit input with R=2, four stages, shift 0.
   int   tab[4] = '{0, 0, 5, 15};

   function automatic int clampr(input int r);
      if (r < 2)    return 2;
      if (r > 4096) return 4096;
      return r;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      b_cnt = 0;
      b_reff = clampr(int'(rate));
      out_idx = 0;
   endtask

   task automatic push_exp;
      exp_t e;
      e.ecyc = cyc + STAGES + 2;
      e.chk = 1'b0;
      e.ei = 0;
      e.eq = 0;
      if (use_tab && out_idx < 4) begin
         e.ei = tab[out_idx] * ai;
         e.eq = tab[out_idx] * aq;
         e.chk = 1'b1;
      end else if (out_idx >= 4) begin
         e.ei = st_i;
         e.eq = st_q;
         e.chk = 1'b1;
      end
      if (push_left != 0) begin
         q_exp.push_back(e);
         if (push_left > 0) push_left--;
      end
      out_idx++;
   endtask

   task automatic run(input int n, input int gap, input int vi, input int vq);
      for (int s = 0; s < n; s++) begin
         in_valid = 1'b1;
         in_i = IN_W'(vi);
         in_q = IN_W'(vq);
         if (b_cnt == b_reff - 1) begin
            push_exp();
            b_cnt = 0;
            b_reff = clampr(int'(rate));
         end else begin
            b_cnt++;
         end
         step();
         in_valid = 1'b0;
         repeat (gap) step();
      end
   endtask

   task automatic drain;
      int t;
      t = 0;
      while (q_exp.size() != 0 && t < 200) begin
         step();
         t++;
      end
      n_chk++;
      if (q_exp.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected results never arrived, expected 0 pending", q_exp.size());
         q_exp.delete();
      end
      repeat (4) step();
   endtask

   initial begin : monitor
      bit   prev_v, prev_hs;
      exp_t e;
      prev_v = 1'b0;
      prev_hs = 1'b0;
      forever begin
         @(negedge clk);
         if (out_valid && (!prev_v || prev_hs)) begin
            n_arr++;
            if (q_exp.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_out: out_valid=1 with out_i=%0d at cycle %0d, expected no result",
                        out_i, cyc);
            end else begin
               e = q_exp.pop_front();
               chk("latency", cyc, e.ecyc);
               if (e.chk) begin
                  chk("out_i", longint'(out_i), e.ei);
                  chk("out_q", longint'(out_q), e.eq);
               end
            end
         end
         prev_v = out_valid;
         prev_hs = out_valid && out_ready;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin : stim
      repeat (3) step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_i", longint'(out_i), 0);
      chk("rst_out_q", longint'(out_q), 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_sat", sat, 0);

      // DC gain 16^4 = 65536, shift 16 -> +1 / -1
      rate = 13'd16; shift = 6'd16; use_tab = 1'b0; st_i = 1; st_q = -1;
      do_reset();
      run(128, 0, 1, -1);
      drain();
      chk("t1_sat", sat, 0);
      chk("t1_overrun", overrun, 0);

      // shift 0 -> saturation both directions
      shift = 6'd0; st_i = 32767; st_q = -32768;
      do_reset();
      run(128, 0, 1, -1);
      drain();
      chk("t2_sat", sat, 1);

      // rate 0 clamps to 2: gain 16, shift 4, extreme inputs
      rate = 13'd0; shift = 6'd4; st_i = 127; st_q = -128;
      do_reset();
      chk("t3_sat_cleared", sat, 0);
      n_arr = 0;
      run(20, 0, 127, -128);
      drain();
      chk("t3_arrivals", n_arr, 10);

      // gapped input, 1 strobe in 3 cycles: R=4 gain 256, shift 8
      rate = 13'd4; shift = 6'd8; st_i = -7; st_q = 3;
      do_reset();
      run(32, 2, -7, 3);
      drain();

      // shift equal to ACC_W (56) -> sign only
      rate = 13'd16; shift = 6'd56; st_i = 0; st_q = -1;
      do_reset();
      run(96, 0, 1, -1);
      drain();
      chk("t5_sat", sat, 0);

      // rate change mid-period: first period 16, then 8 (gain 4096, shift 12)
      rate = 13'd16; shift = 6'd12; st_i = 1; st_q = -1;
      do_reset();
      run(5, 0, 1, -1);
      rate = 13'd8;
      run(67, 0, 1, -1);
      drain();

      // reset while a result is inside the comb pipeline
      rate = 13'd16; shift = 6'd16;
      do_reset();
      push_left = 0;
      run(16, 0, 1, 1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      push_left = -1;
      b_cnt = 0; b_reff = 16; out_idx = 0;
      repeat (12) step();
      chk("t7_out_valid", out_valid, 0);
      chk("t7_out_i", longint'(out_i), 0);
      chk("t7_out_q", longint'(out_q), 0);

      // overrun: out_ready low across later arrivals, latest value held
      rate = 13'd2; shift = 6'd0; use_tab = 1'b1; ai = 1; aq = 2; st_i = 16; st_q = 32;
      out_ready = 1'b0;
      do_reset();
      push_left = 1;
      run(8, 0, 1, 2);
      repeat (7) step();
      chk("t8_out_valid", out_valid, 1);
      chk("t8_out_i", longint'(out_i), 15);
      chk("t8_out_q", longint'(out_q), 30);
      chk("t8_overrun", overrun, 1);
      out_ready = 1'b1;
      step();
      chk("t8_valid_drop", out_valid, 0);
      push_left = -1;
      drain();

      // arrival coinciding with handshake: no overrun
      ai = 1; aq = -1; st_i = 16; st_q = -16;
      out_ready = 1'b0;
      do_reset();
      chk("t9_overrun_cleared", overrun, 0);
      fork
         run(16, 0, 1, -1);
         begin
            repeat (8) step();
            out_ready = 1'b1;
         end
      join
      drain();
      chk("t9_overrun", overrun, 0);
      chk("t9_sat", sat, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
